// File: rtl/jk_mode_register.sv
// rtl/jk_mode_register.sv - multi-mode JK/up/down/shift register with load, terminal count and overflow tracking
module jk_mode_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             sin,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_flag
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_next;
    logic             boundary;

    assign qb = ~q;

    // Terminal count depends only on mode and state, never on en.
    always_comb begin
        tc = 1'b0;
        if (mode == MODE_UP && q == ALL_ONES) begin
            tc = 1'b1;
        end else if (mode == MODE_DOWN && q == ALL_ZERO) begin
            tc = 1'b1;
        end
    end

    // A boundary event needs an enabled count cycle at the terminal value; tc already implies a count mode.
    assign boundary = en & ~load & tc;

    // Next state for the selected run mode; saturation only changes behaviour at the boundary.
    always_comb begin
        q_next = q;
        case (mode)
            MODE_JK:    q_next = (j & ~q) | (~k & q);
            MODE_UP:    q_next = (tc && SATURATE) ? q : q + ONE;
            MODE_DOWN:  q_next = (tc && SATURATE) ? q : q - ONE;
            MODE_SHIFT: q_next = {q[WIDTH-2:0], sin};
            default:    q_next = q;
        endcase
    end

    // State register: reset beats load beats enable beats mode action.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= d;
            wrap <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= boundary;
        end
    end

    // Sticky overflow: a boundary event in the same cycle overrides a clear request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
        end else if (boundary) begin
            ovf_flag <= 1'b1;
        end else if (clr_ovf) begin
            ovf_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jk_mode_register.sv
// tb/tb_jk_mode_register.sv - directed self-checking bench for jk_mode_register
module tb_jk_mode_register;

    logic       clk = 1'b0;
    logic       rst_n, en, load, sin, clr_ovf;
    logic [3:0] d, j, k;
    logic [1:0] mode;

    logic [3:0] qa, qba, qs, qbs;
    logic       tca, wrapa, ovfa, tcs, wraps, ovfs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jk_mode_register #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .d(d), .mode(mode),
        .j(j), .k(k), .sin(sin), .clr_ovf(clr_ovf),
        .q(qa), .qb(qba), .tc(tca), .wrap(wrapa), .ovf_flag(ovfa)
    );

    jk_mode_register #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .d(d), .mode(mode),
        .j(j), .k(k), .sin(sin), .clr_ovf(clr_ovf),
        .q(qs), .qb(qbs), .tc(tcs), .wrap(wraps), .ovf_flag(ovfs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b1; d = 4'hA; en = 1'b0; mode = 2'b00;
        j = 4'h0; k = 4'h0; sin = 1'b0; clr_ovf = 1'b0;

        // reset beats load
        tick(); tick();
        chk("rst_q",    qa,    4'h5);
        chk("rst_qb",   qba,   4'hA);
        chk("rst_wrap", wrapa, 1'b0);
        chk("rst_ovf",  ovfa,  1'b0);
        chk("rst_q_s",  qs,    4'h5);

        rst_n = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        chk("rel_hold", qa, 4'h5);

        // JK mode
        load = 1'b1; d = 4'b1010;
        tick();
        chk("jk_load", qa, 4'b1010);
        load = 1'b0; en = 1'b1; mode = 2'b00; j = 4'b0110; k = 4'b0011;
        tick();
        chk("jk_1",  qa,  4'b1100);
        chk("jk_tc", tca, 1'b0);
        tick();
        chk("jk_2", qa, 4'b1110);
        en = 1'b0;
        tick();
        chk("jk_hold", qa, 4'b1110);

        // up count: wrap vs saturate
        load = 1'b1; d = 4'hE;
        tick();
        chk("up_load", qa, 4'hE);
        load = 1'b0; mode = 2'b01; en = 1'b1;
        #1;
        chk("up_tc_e", tca, 1'b0);
        tick();
        chk("up_q_f",    qa,    4'hF);
        chk("up_tc_f",   tca,   1'b1);
        chk("up_wrap_f", wrapa, 1'b0);
        tick();
        chk("up_q_0",    qa,    4'h0);
        chk("up_tc_0",   tca,   1'b0);
        chk("up_wrap_0", wrapa, 1'b1);
        chk("up_ovf_0",  ovfa,  1'b1);
        chk("up_sat_q",  qs,    4'hF);
        chk("up_sat_wr", wraps, 1'b1);
        tick();
        chk("up_q_1",    qa,    4'h1);
        chk("up_wrap_1", wrapa, 1'b0);
        chk("up_ovf_1",  ovfa,  1'b1);
        en = 1'b0; clr_ovf = 1'b1;
        tick();
        chk("clr_ovf",   ovfa,  1'b0);
        chk("clr_ovf_s", ovfs,  1'b0);
        chk("en0_wrap",  wraps, 1'b0);
        clr_ovf = 1'b0;

        // down count with saturation
        load = 1'b1; d = 4'h1;
        tick();
        chk("dn_load", qs, 4'h1);
        load = 1'b0; mode = 2'b10; en = 1'b1;
        tick();
        chk("dn_q_0",    qs,    4'h0);
        chk("dn_tc_0",   tcs,   1'b1);
        chk("dn_wrap_a", wraps, 1'b0);
        clr_ovf = 1'b1;
        tick();
        chk("dn_q_b",    qs,    4'h0);
        chk("dn_wrap_b", wraps, 1'b1);
        chk("dn_ovf_b",  ovfs,  1'b1);
        chk("dn_wrapq",  qa,    4'hF);
        tick();
        chk("dn_q_c",    qs,    4'h0);
        chk("dn_wrap_c", wraps, 1'b1);
        chk("dn_ovf_c",  ovfs,  1'b1);
        chk("dn_wq_c",   qa,    4'hE);
        chk("dn_wovf_c", ovfa,  1'b0);
        clr_ovf = 1'b0;

        // shift left
        load = 1'b1; d = 4'b1001;
        tick();
        load = 1'b0; mode = 2'b11; en = 1'b1; sin = 1'b1;
        tick();
        chk("sh_1",  qa,  4'b0011);
        chk("sh_tc", tca, 1'b0);
        sin = 1'b0;
        tick();
        chk("sh_2", qa, 4'b0110);
        sin = 1'b1;
        tick();
        chk("sh_3", qa, 4'b1101);

        // priority: load over count, reset over load
        mode = 2'b01; en = 1'b1; load = 1'b1; d = 4'hF;
        tick();
        chk("pr_tc", tcs, 1'b1);
        d = 4'h3;
        tick();
        chk("pr_q",    qs,    4'h3);
        chk("pr_wrap", wraps, 1'b0);
        chk("pr_ovf",  ovfs,  1'b1);
        rst_n = 1'b0;
        tick();
        chk("pr_rst_q",   qs,   4'h5);
        chk("pr_rst_qb",  qbs,  4'hA);
        chk("pr_rst_ovf", ovfs, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
